// File: rtl/xbar_pkg.sv
// Shared types and helpers for the crossbar output-port scheduler.
// Optional perf counters are enabled with XBAR_ARB_PERF_EN.
package xbar_pkg;

  localparam int N_REQ = 4;
  localparam int SEL_W = $clog2(N_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  function automatic logic [SEL_W-1:0] oh2idx(
    input logic [N_REQ-1:0] oh
  );
    logic [SEL_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (oh[i]) idx = idx | SEL_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/xbar_output_arbiter_rr_arbiter.sv
// Round-robin pick from the request vector, searching upward from a
// registered pointer that advances past the winner on each strobe.
module rr_arbiter #(
  parameter int N_REQ = 4,
  parameter int SEL_W = $clog2(N_REQ)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             adv,
  input  logic [SEL_W-1:0] adv_idx,
  output logic [SEL_W-1:0] pick,
  output logic             vld
);

  logic [SEL_W-1:0] ptr;

  // Walk from lowest priority down so the highest-priority hit wins.
  always_comb begin
    int idx;
    pick = '0;
    vld  = 1'b0;
    idx  = 0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (req[SEL_W'(idx)]) begin
        pick = SEL_W'(idx);
        vld  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr <= '0;
    end else if (adv) begin
      if (int'(adv_idx) == N_REQ - 1) ptr <= '0;
      else ptr <= adv_idx + SEL_W'(1);
    end
  end

endmodule

// File: rtl/xbar_output_arbiter.sv
// Per-output-port burst scheduler: round-robin grant, fixed bursts.
// XBAR_ARB_PERF_EN adds burst_cnt and wait_max counters.
module xbar_output_arbiter #(
  parameter int N_REQ     = 4,
  parameter int ADDR_W    = 10,
  parameter int BURST_LEN = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         gnt,
  output logic [$clog2(N_REQ)-1:0] sel,
  output logic                     cen,
  output logic                     start,
  output logic [ADDR_W-1:0]        addr,
  output logic [N_REQ-1:0]         done,
  output logic                     busy
`ifdef XBAR_ARB_PERF_EN
  ,
  output logic [15:0]              burst_cnt,
  output logic [7:0]               wait_max
`endif
);

  import xbar_pkg::*;

  localparam int SW = $clog2(N_REQ);
  localparam int BW = $clog2(BURST_LEN);

  state_t      state;
  logic [BW-1:0] beat;
  logic [ADDR_W-1:0] base;
  logic [SW-1:0] pick;
  logic [SW-1:0] widx;
  logic        vld;
  logic        last;
  logic        adv;

  assign last = (beat == BW'(BURST_LEN - 1));
  assign adv  = (state == BURST) && last;
  assign widx = oh2idx(gnt);

  rr_arbiter #(
    .N_REQ (N_REQ),
    .SEL_W (SW)
  ) u_rr (
    .clk     (clk),
    .rst     (rst),
    .req     (req),
    .adv     (adv),
    .adv_idx (widx),
    .pick    (pick),
    .vld     (vld)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      gnt   <= '0;
      sel   <= '0;
      cen   <= 1'b0;
      start <= 1'b0;
      addr  <= '0;
      done  <= '0;
      busy  <= 1'b0;
      beat  <= '0;
      base  <= '0;
    end else begin
      done  <= '0;
      start <= 1'b0;
      unique case (state)
        IDLE: begin
          if (vld) begin
            state <= BURST;
            gnt   <= N_REQ'(1) << pick;
            sel   <= pick;
            cen   <= 1'b1;
            start <= 1'b1;
            addr  <= base;
            beat  <= '0;
            busy  <= 1'b1;
          end
        end
        BURST: begin
          if (last) begin
            state <= IDLE;
            gnt   <= '0;
            cen   <= 1'b0;
            busy  <= 1'b0;
            done  <= gnt;
            base  <= base + ADDR_W'(BURST_LEN);
          end else begin
            beat <= beat + 1'b1;
            addr <= addr + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef XBAR_ARB_PERF_EN
  logic [7:0] wcnt  [N_REQ];
  logic [7:0] wnext [N_REQ];
  logic [7:0] wpeak;

  // A port waits on every cycle it requests without holding the grant.
  always_comb begin
    wpeak = wait_max;
    for (int i = 0; i < N_REQ; i++) begin
      wnext[i] = 8'h00;
      if (req[i] && !gnt[i]) begin
        wnext[i] = (wcnt[i] == 8'hFF) ? 8'hFF : wcnt[i] + 8'h01;
      end
      if (wnext[i] > wpeak) wpeak = wnext[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      burst_cnt <= '0;
      wait_max  <= '0;
      for (int i = 0; i < N_REQ; i++) wcnt[i] <= '0;
    end else begin
      if (adv && burst_cnt != 16'hFFFF) burst_cnt <= burst_cnt + 16'h0001;
      wait_max <= wpeak;
      for (int i = 0; i < N_REQ; i++) wcnt[i] <= wnext[i];
    end
  end
`endif

endmodule

// File: tb/tb_xbar_output_arbiter.sv
// Randomized self-checking bench for xbar_output_arbiter.
// Define XBAR_ARB_PERF_EN to also exercise the perf counters.
module tb_xbar_output_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] gnt;
  logic [1:0] sel;
  logic       cen;
  logic       start;
  logic [9:0] addr;
  logic [3:0] done;
  logic       busy;
`ifdef XBAR_ARB_PERF_EN
  logic [15:0] burst_cnt;
  logic [7:0]  wait_max;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int m_ptr   = 0;
  int m_base  = 0;

  always #5 clk = ~clk;

  xbar_output_arbiter #(
    .N_REQ     (4),
    .ADDR_W    (10),
    .BURST_LEN (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .req   (req),
    .gnt   (gnt),
    .sel   (sel),
    .cen   (cen),
    .start (start),
    .addr  (addr),
    .done  (done),
    .busy  (busy)
`ifdef XBAR_ARB_PERF_EN
    ,
    .burst_cnt (burst_cnt),
    .wait_max  (wait_max)
`endif
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int rr_pick(input logic [3:0] r, input int p);
    logic [1:0] i2;
    for (int k = 0; k < 4; k++) begin
      i2 = 2'((p + k) % 4);
      if (r[i2]) return (p + k) % 4;
    end
    return -1;
  endfunction

  // Expected observation of one complete burst for winner w at base b.
  function automatic logic [63:0] burst_exp(input int lat, input int w,
                                            input int b);
    return {4'(lat), 4'(1 << w), 2'(w),
            10'(b + 3), 10'(b + 2), 10'(b + 1), 10'(b),
            4'b0001, 4'b1111, 1'b1, 4'(1 << w), 1'b0};
  endfunction

  task automatic model_done(input int w);
    m_ptr  = (w + 1) % 4;
    m_base = (m_base + 4) % 1024;
  endtask

  // Collect one burst: latency to grant, each beat, then the done cycle.
  task automatic watch(input int drop_beat, input logic [3:0] drop_mask,
                       output logic [63:0] obs);
    int lat;
    logic [3:0] g;
    logic [1:0] s;
    logic [3:0][9:0] a;
    logic [3:0] st;
    logic [3:0] ce;
    logic stab;
    logic [3:0] dn;
    logic tail;
    lat = 0;
    while (gnt == 4'b0 && lat < 40) begin
      step();
      lat++;
    end
    g = gnt;
    s = sel;
    stab = 1'b1;
    for (int b = 0; b < 4; b++) begin
      if (b > 0) step();
      a[b]  = addr;
      st[b] = start;
      ce[b] = cen & busy;
      if (gnt !== g || sel !== s) stab = 1'b0;
      if (b == drop_beat) req = req & ~drop_mask;
    end
    step();
    dn   = done;
    tail = cen | busy | start | (|gnt);
    obs  = {4'(lat), g, s, a, st, ce, stab, dn, tail};
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'b0;
    step();
    step();
    rst = 1'b0;
    m_ptr  = 0;
    m_base = 0;
  endtask

  task automatic test_reset();
    logic [22:0] obs;
    do_reset();
    obs = {gnt, sel, cen, start, addr, busy, done};
    n_tests++;
    if (obs !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_state got=%h want=%h", obs, 23'h0);
    end
  endtask

  task automatic test_single();
    logic [63:0] obs;
    logic [63:0] exp;
    int w;
    req = 4'b0100;
    w = rr_pick(req, m_ptr);
    step();
    req = 4'b0000;
    watch(-1, 4'b0, obs);
    exp = burst_exp(0, w, m_base);
    model_done(w);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL single_burst got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_idle_hold();
    logic [10:0] obs;
    req = 4'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      obs = {gnt, done, cen, busy, start};
      n_tests++;
      if (obs !== 11'h0) begin
        n_fail++;
        $display("FAIL idle_hold got=%h want=%h", obs, 11'h0);
      end
    end
  endtask

  task automatic test_rr_held();
    logic [63:0] obs;
    logic [63:0] exp;
    int w;
    int order[5] = '{0, 1, 2, 3, 0};
    do_reset();
    req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      w = rr_pick(req, m_ptr);
      watch(-1, 4'b0, obs);
      exp = burst_exp(1, order[i], 4 * i);
      model_done(w);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL rr_held[%0d] got=%h want=%h", i, obs, exp);
      end
    end
  endtask

  task automatic test_wrap();
    logic [63:0] obs;
    logic [63:0] exp;
    int w;
    int guard;
    req = 4'b1111;
    guard = 0;
    while (m_base != 1020 && guard < 300) begin
      w = rr_pick(req, m_ptr);
      watch(-1, 4'b0, obs);
      exp = burst_exp(1, w, m_base);
      model_done(w);
      guard++;
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL wrap_fill got=%h want=%h", obs, exp);
      end
    end
    for (int i = 0; i < 2; i++) begin
      w = rr_pick(req, m_ptr);
      watch(-1, 4'b0, obs);
      exp = burst_exp(1, w, (i == 0) ? 1020 : 0);
      model_done(w);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL wrap_edge[%0d] got=%h want=%h", i, obs, exp);
      end
    end
    req = 4'b0;
  endtask

  task automatic test_drop();
    logic [63:0] obs;
    logic [63:0] exp;
    step();
    req = 4'b0010;
    watch(1, 4'b0010, obs);
    exp = burst_exp(1, 1, m_base);
    model_done(1);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL req_drop got=%h want=%h", obs, exp);
    end
  endtask

  task automatic test_reset_mid();
    logic [22:0] obs;
    logic [22:0] want;
    logic [63:0] bobs;
    logic [63:0] bexp;
    req = 4'b0100;
    step();
    step();
    step();
    rst = 1'b1;
    req = 4'b0;
    step();
    obs = {gnt, sel, cen, start, addr, busy, done};
    n_tests++;
    if (obs !== 23'h0) begin
      n_fail++;
      $display("FAIL reset_mid got=%h want=%h", obs, 23'h0);
    end
    rst = 1'b0;
    m_ptr  = 0;
    m_base = 0;
    req = 4'b0001;
    step();
    obs  = {gnt, sel, cen, start, addr, busy, done};
    want = {4'b0001, 2'd0, 1'b1, 1'b1, 10'd0, 1'b1, 4'b0};
    n_tests++;
    if (obs !== want) begin
      n_fail++;
      $display("FAIL reset_regrant got=%h want=%h", obs, want);
    end
    watch(0, 4'b0001, bobs);
    bexp = burst_exp(0, 0, 0);
    model_done(0);
    n_tests++;
    if (bobs !== bexp) begin
      n_fail++;
      $display("FAIL reset_burst got=%h want=%h", bobs, bexp);
    end
  endtask

  task automatic test_random();
    logic [63:0] obs;
    logic [63:0] exp;
    logic [3:0] p;
    int w;
    int waits[4] = '{0, 0, 0, 0};
    int mx;
    p = 4'b0;
    for (int n = 0; n < 40; n++) begin
      p = p | 4'($urandom_range(0, 15));
      if (p == 4'b0) p = 4'(1 << $urandom_range(0, 3));
      req = p;
      w = rr_pick(p, m_ptr);
      watch(-1, 4'b0, obs);
      exp = burst_exp(1, w, m_base);
      model_done(w);
      n_tests++;
      if (obs !== exp) begin
        n_fail++;
        $display("FAIL random[%0d] got=%h want=%h", n, obs, exp);
      end
      mx = 0;
      for (int i = 0; i < 4; i++) begin
        if (i == w) waits[i] = 0;
        else if (p[i]) waits[i]++;
        if (waits[i] > mx) mx = waits[i];
      end
      n_tests++;
      if (mx > 3) begin
        n_fail++;
        $display("FAIL fairness[%0d] got=%0d want<=3", n, mx);
      end
      if ($urandom_range(0, 1) == 0) p = p & ~4'(1 << w);
    end
    req = 4'b0;
    step();
  endtask

`ifdef XBAR_ARB_PERF_EN
  task automatic test_perf();
    logic [63:0] obs;
    do_reset();
    req = 4'b0001;
    for (int i = 0; i < 3; i++) watch(-1, 4'b0, obs);
    req = 4'b0;
    step();
    n_tests++;
    if (burst_cnt !== 16'd3) begin
      n_fail++;
      $display("FAIL burst_cnt got=%0d want=3", burst_cnt);
    end
    do_reset();
    req = 4'b0001;
    step();
    req = 4'b1000;
    for (int i = 0; i < 5; i++) step();
    n_tests++;
    if ({gnt, wait_max} !== {4'b1000, 8'd5}) begin
      n_fail++;
      $display("FAIL wait_max got=%h/%0d want=8/5", gnt, wait_max);
    end
    req = 4'b0;
  endtask
`endif

  initial begin
    rst = 1'b1;
    req = 4'b0;
    test_reset();
    test_single();
    test_idle_hold();
    test_rr_held();
    test_wrap();
    test_drop();
    test_reset_mid();
    test_random();
`ifdef XBAR_ARB_PERF_EN
    test_perf();
`endif
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
